// File: rtl/dmem_arbiter.sv
// Round-robin arbiter sharing a single-ported data memory between requester A and B.
// Each grant performs one memory access and answers with a one-cycle ack and registered data.
module dmem_arbiter #(
  parameter int unsigned RAM_SIZE = 256,
  parameter int unsigned DATA_W   = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              a_req,
  input  logic              a_wr,
  input  logic [31:0]       a_addr,
  input  logic [DATA_W-1:0] a_wdata,
  output logic              a_ack,
  output logic [DATA_W-1:0] a_rdata,
  output logic              a_err,
  input  logic              b_req,
  input  logic              b_wr,
  input  logic [31:0]       b_addr,
  input  logic [DATA_W-1:0] b_wdata,
  output logic              b_ack,
  output logic [DATA_W-1:0] b_rdata,
  output logic              b_err,
  output logic              mem_rd,
  output logic              mem_wr,
  output logic [31:0]       mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              busy
);

  typedef enum logic [1:0] {S_IDLE, S_ACCESS, S_RESP} state_e;

  state_e              state_q, state_d;
  logic                owner_q, owner_d;   // 0 = A, 1 = B
  logic                rr_q, rr_d;         // port preferred on a tie
  logic                wr_q, wr_d;
  logic [31:0]         addr_q, addr_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;
  logic                a_ack_q, a_ack_d, a_err_q, a_err_d;
  logic                b_ack_q, b_ack_d, b_err_q, b_err_d;
  logic [DATA_W-1:0]   a_rdata_q, a_rdata_d, b_rdata_q, b_rdata_d;
  logic                legal;
  logic                grant, grant_b;

  assign legal = (addr_q[1:0] == 2'b00) && ({2'b00, addr_q[31:2]} < RAM_SIZE);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= S_IDLE;
      owner_q   <= 1'b0;
      rr_q      <= 1'b0;
      wr_q      <= 1'b0;
      addr_q    <= '0;
      wdata_q   <= '0;
      a_ack_q   <= 1'b0;
      a_err_q   <= 1'b0;
      b_ack_q   <= 1'b0;
      b_err_q   <= 1'b0;
      a_rdata_q <= '0;
      b_rdata_q <= '0;
    end else begin
      state_q   <= state_d;
      owner_q   <= owner_d;
      rr_q      <= rr_d;
      wr_q      <= wr_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      a_ack_q   <= a_ack_d;
      a_err_q   <= a_err_d;
      b_ack_q   <= b_ack_d;
      b_err_q   <= b_err_d;
      a_rdata_q <= a_rdata_d;
      b_rdata_q <= b_rdata_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    owner_d   = owner_q;
    rr_d      = rr_q;
    wr_d      = wr_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    a_ack_d   = 1'b0;
    a_err_d   = 1'b0;
    b_ack_d   = 1'b0;
    b_err_d   = 1'b0;
    a_rdata_d = a_rdata_q;
    b_rdata_d = b_rdata_q;
    grant     = 1'b0;
    grant_b   = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (a_req || b_req) begin
          grant   = 1'b1;
          grant_b = (a_req && b_req) ? rr_q : b_req;
        end
      end
      S_ACCESS: begin
        state_d = S_RESP;
        if (!owner_q) begin
          a_ack_d = 1'b1;
          a_err_d = ~legal;
          if (!legal)     a_rdata_d = '0;
          else if (!wr_q) a_rdata_d = mem_rdata;
        end else begin
          b_ack_d = 1'b1;
          b_err_d = ~legal;
          if (!legal)     b_rdata_d = '0;
          else if (!wr_q) b_rdata_d = mem_rdata;
        end
      end
      S_RESP: begin
        // The owner's req is ignored here; only the other port can get a back-to-back grant.
        if (owner_q ? a_req : b_req) begin
          grant   = 1'b1;
          grant_b = ~owner_q;
        end else begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
    if (grant) begin
      state_d = S_ACCESS;
      owner_d = grant_b;
      rr_d    = ~grant_b;
      wr_d    = grant_b ? b_wr    : a_wr;
      addr_d  = grant_b ? b_addr  : a_addr;
      wdata_d = grant_b ? b_wdata : a_wdata;
    end
  end

  assign mem_rd    = (state_q == S_ACCESS) && legal && !wr_q;
  assign mem_wr    = (state_q == S_ACCESS) && legal && wr_q;
  assign mem_addr  = (state_q == S_ACCESS) ? addr_q  : '0;
  assign mem_wdata = (state_q == S_ACCESS) ? wdata_q : '0;
  assign busy      = (state_q != S_IDLE);

  assign a_ack   = a_ack_q;
  assign a_err   = a_err_q;
  assign a_rdata = a_rdata_q;
  assign b_ack   = b_ack_q;
  assign b_err   = b_err_q;
  assign b_rdata = b_rdata_q;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Bench for dmem_arbiter: transaction-level model checked every cycle plus directed scenarios.
module tb_dmem_arbiter;
  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        a_req = 1'b0, a_wr = 1'b0, b_req = 1'b0, b_wr = 1'b0;
  logic [31:0] a_addr = '0, a_wdata = '0, b_addr = '0, b_wdata = '0;
  logic        a_ack, a_err, b_ack, b_err, mem_rd, mem_wr, busy;
  logic [31:0] a_rdata, b_rdata, mem_addr, mem_wdata, mem_rdata;

  int total = 0;
  int bad   = 0;
  int cyc_now = 0;
  int busy_cnt = 0, a_ack_cnt = 0, memwr_cnt = 0;
  bit mvalid = 1'b0;

  logic [31:0] bmem   [256];
  logic [31:0] shadow [256];

  dmem_arbiter #(.RAM_SIZE(256), .DATA_W(32)) dut (
    .clk(clk), .reset(rst_n),
    .a_req(a_req), .a_wr(a_wr), .a_addr(a_addr), .a_wdata(a_wdata),
    .a_ack(a_ack), .a_rdata(a_rdata), .a_err(a_err),
    .b_req(b_req), .b_wr(b_wr), .b_addr(b_addr), .b_wdata(b_wdata),
    .b_ack(b_ack), .b_rdata(b_rdata), .b_err(b_err),
    .mem_rd(mem_rd), .mem_wr(mem_wr), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .busy(busy)
  );

  always #5 clk = ~clk;

  assign mem_rdata = bmem[mem_addr[9:2]];
  always @(posedge clk) if (mem_wr) bmem[mem_addr[9:2]] <= mem_wdata;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc_now);
    end
  endtask

  function automatic bit addr_ok(input logic [31:0] ad);
    return (ad % 4 == 0) && (ad < 32'd1024);
  endfunction

  // Model: phase 0 = idle, 1 = memory access in flight, 2 = answering the owner
  int          m_phase = 0, m_owner = 0, m_pref = 0;
  logic        m_wr = 1'b0, m_err = 1'b0;
  logic [31:0] m_addr = '0, m_wdata = '0;
  logic [31:0] m_rdata [2];

  initial begin
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) begin
        m_phase = 0; m_owner = 0; m_pref = 0; m_wr = 1'b0; m_err = 1'b0;
        m_addr = '0; m_wdata = '0; m_rdata[0] = '0; m_rdata[1] = '0;
        mvalid = 1'b1;
      end else if (m_phase == 1) begin
        if (!addr_ok(m_addr))  m_rdata[m_owner] = '0;
        else if (m_wr)         shadow[m_addr / 4] = m_wdata;
        else                   m_rdata[m_owner] = shadow[m_addr / 4];
        m_err   = !addr_ok(m_addr);
        m_phase = 2;
      end else begin
        bit ea, eb;
        int win;
        ea  = a_req && !(m_phase == 2 && m_owner == 0);
        eb  = b_req && !(m_phase == 2 && m_owner == 1);
        win = (ea && eb) ? m_pref : ea ? 0 : eb ? 1 : -1;
        if (win >= 0) begin
          m_owner = win;
          m_pref  = 1 - win;
          m_wr    = (win == 0) ? a_wr    : b_wr;
          m_addr  = (win == 0) ? a_addr  : b_addr;
          m_wdata = (win == 0) ? a_wdata : b_wdata;
          m_phase = 1;
        end else begin
          m_phase = 0;
        end
      end
    end
  end

  initial begin
    forever begin
      bit acc;
      @(posedge clk);
      cyc_now++;
      #1;
      if (mvalid) begin
        acc = (m_phase == 1);
        chk("busy",      busy,      m_phase != 0);
        chk("a_ack",     a_ack,     m_phase == 2 && m_owner == 0);
        chk("b_ack",     b_ack,     m_phase == 2 && m_owner == 1);
        chk("a_err",     a_err,     m_phase == 2 && m_owner == 0 && m_err);
        chk("b_err",     b_err,     m_phase == 2 && m_owner == 1 && m_err);
        chk("a_rdata",   a_rdata,   m_rdata[0]);
        chk("b_rdata",   b_rdata,   m_rdata[1]);
        chk("mem_rd",    mem_rd,    acc && addr_ok(m_addr) && !m_wr);
        chk("mem_wr",    mem_wr,    acc && addr_ok(m_addr) && m_wr);
        chk("mem_addr",  mem_addr,  acc ? m_addr  : 32'h0);
        chk("mem_wdata", mem_wdata, acc ? m_wdata : 32'h0);
        chk("ack_overlap", a_ack & b_ack, 1'b0);
        if (busy)   busy_cnt++;
        if (a_ack)  a_ack_cnt++;
        if (mem_wr) memwr_cnt++;
      end
    end
  end

  task automatic do_acc(input int p, input logic w, input logic [31:0] ad, input logic [31:0] wd,
                        output int lat, output int at, output logic [31:0] rd, output logic er);
    @(negedge clk);
    if (p == 0) begin a_req = 1'b1; a_wr = w; a_addr = ad; a_wdata = wd; end
    else        begin b_req = 1'b1; b_wr = w; b_addr = ad; b_wdata = wd; end
    lat = 0; at = -1; rd = '0; er = 1'b0;
    while (at < 0 && lat < 30) begin
      @(posedge clk); #1;
      lat++;
      if ((p == 0) ? a_ack : b_ack) begin
        at = cyc_now;
        rd = (p == 0) ? a_rdata : b_rdata;
        er = (p == 0) ? a_err : b_err;
      end
    end
    if (at < 0) begin
      total++; bad++;
      $display("FAIL ack_timeout: port %0d got no ack within %0d cycles", p, lat);
    end
    @(negedge clk);
    if (p == 0) a_req = 1'b0; else b_req = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    int lat, lat2, ta, tb, snap, snap2;
    int a_t [4];
    logic [31:0] rd, rd2;
    logic er, er2;

    for (int unsigned i = 0; i < 256; i++) begin
      bmem[i]   = i * 32'h0101_0101;
      shadow[i] = i * 32'h0101_0101;
    end
    #3 rst_n = 1'b0;
    #1;
    chk("rst_busy", busy, 1'b0);
    chk("rst_mem_wr", mem_wr, 1'b0);
    chk("rst_a_rdata", a_rdata, 32'h0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    // 1: write then read back
    snap = memwr_cnt;
    do_acc(0, 1'b1, 32'h10, 32'hDEAD_BEEF, lat, ta, rd, er);
    chk("t1_wr_latency", lat, 2);
    chk("t1_memwr_cycles", memwr_cnt - snap, 1);
    chk("t1_mem_word4", bmem[4], 32'hDEAD_BEEF);
    do_acc(0, 1'b0, 32'h10, 32'h0, lat, ta, rd, er);
    chk("t1_rd_data", rd, 32'hDEAD_BEEF);
    chk("t1_rd_err", er, 1'b0);

    // 2: simultaneous requests, round robin
    do_reset();
    fork
      do_acc(0, 1'b0, 32'h10, 32'h0, lat, ta, rd, er);
      do_acc(1, 1'b0, 32'h14, 32'h0, lat2, tb, rd2, er2);
    join
    chk("t2_a_latency", lat, 2);
    chk("t2_b_after_a", tb - ta, 2);
    chk("t2_b_rdata", rd2, 32'h0505_0505);
    do_acc(0, 1'b0, 32'h10, 32'h0, lat, ta, rd, er);
    fork
      do_acc(0, 1'b0, 32'h10, 32'h0, lat, ta, rd, er);
      do_acc(1, 1'b0, 32'h14, 32'h0, lat2, tb, rd2, er2);
    join
    chk("t2b_b_latency", lat2, 2);
    chk("t2b_a_after_b", ta - tb, 2);

    // 3: illegal B writes
    do_acc(1, 1'b0, 32'h10, 32'h0, lat, tb, rd, er);
    chk("t3_b_pre_rdata", rd, 32'hDEAD_BEEF);
    snap = memwr_cnt;
    do_acc(1, 1'b1, 32'h400, 32'h1111_2222, lat, tb, rd, er);
    chk("t3_oob_err", er, 1'b1);
    chk("t3_oob_rdata", rd, 32'h0);
    do_acc(1, 1'b1, 32'h13, 32'h3333_4444, lat, tb, rd, er);
    chk("t3_mis_err", er, 1'b1);
    chk("t3_mis_rdata", rd, 32'h0);
    chk("t3_no_memwr", memwr_cnt - snap, 0);
    chk("t3_word0", bmem[0], 32'h0);
    chk("t3_word4", bmem[4], 32'hDEAD_BEEF);

    // 4: A held across four accesses, B requests once
    fork
      begin
        int n, g;
        @(negedge clk);
        a_req = 1'b1; a_wr = 1'b0; a_addr = 32'h10;
        n = 0; g = 0;
        while (n < 4 && g < 40) begin
          @(posedge clk); #1;
          g++;
          if (a_ack) begin a_t[n] = cyc_now; n++; end
        end
        @(negedge clk);
        a_req = 1'b0;
        chk("t4_a_acks", n, 4);
      end
      begin
        @(negedge clk);
        do_acc(1, 1'b0, 32'h8, 32'h0, lat, tb, rd, er);
      end
    join
    chk("t4_b_before_a2", tb < a_t[1], 1'b1);
    chk("t4_b_rdata", rd, 32'h0202_0202);

    // 5: reset in the middle of a write
    @(negedge clk);
    a_req = 1'b1; a_wr = 1'b1; a_addr = 32'h20; a_wdata = 32'h1234_5678;
    @(posedge clk); #1;
    chk("t5_memwr_before", mem_wr, 1'b1);
    #1;
    rst_n = 1'b0;
    a_req = 1'b0;
    #1;
    chk("t5_memwr_async", mem_wr, 1'b0);
    chk("t5_busy_async", busy, 1'b0);
    chk("t5_addr_async", mem_addr, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    snap = a_ack_cnt;
    repeat (4) @(negedge clk);
    chk("t5_no_ack", a_ack_cnt - snap, 0);
    chk("t5_word8", bmem[8], 32'h0808_0808);

    // 6: single read, busy window and held data
    snap  = busy_cnt;
    snap2 = a_ack_cnt;
    do_acc(0, 1'b0, 32'h10, 32'h0, lat, ta, rd, er);
    repeat (3) @(negedge clk);
    chk("t6_busy_cycles", busy_cnt - snap, 2);
    chk("t6_ack_cycles", a_ack_cnt - snap2, 1);
    chk("t6_rdata", rd, 32'hDEAD_BEEF);
    chk("t6_rdata_held", a_rdata, 32'hDEAD_BEEF);

    for (int unsigned i = 0; i < 256; i++) chk("mem_image", bmem[i], shadow[i]);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1);
  end

endmodule
